dac_readback_rx: RTL and testbench

Receive side of the DAC SPI link. This block captures the serial `sdo_bit` stream that one DAC channel returns during readback frames and assembles it into 16-bit words. Completed words are buffered in a small FIFO that the host drains through the pipe-out endpoint. The block sits beside each `spi_controller` instance and observes that controller's `sclk` and `latch` outputs; it never drives the DAC.

---
 rtl/dac_rb_pkg.sv | 23 ++
 rtl/rb_fifo.sv | 66 ++++++
 rtl/dac_readback_rx.sv | 176 +++++++++++++++++
 tb/tb_dac_readback_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_rb_pkg.sv
// Purpose : shared defaults, FSM encoding and counter helper for the DAC readback receiver.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package dac_rb_pkg;

  localparam int FRAME_BITS_DEF = 24;
  localparam int DATA_BITS_DEF  = 16;

  // Bit counter is 6 bits wide and sticks at its maximum.
  localparam int         BIT_CNT_W   = 6;
  localparam logic [5:0] BIT_CNT_MAX = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } rb_state_t;

  function automatic logic [BIT_CNT_W-1:0] sat_inc(input logic [BIT_CNT_W-1:0] v);
    return (v == BIT_CNT_MAX) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/rb_fifo.sv
// Purpose : synchronous first-word fall-through FIFO holding completed readback words.
// Latency : write visible on rd_data one cycle after the write edge; pop advances head on the rd_en edge.
// Backpr. : write while full is accepted only when a pop happens in the same cycle; rd_en while empty is ignored.
//
// Ports: clk, rst (sync, active high); wr_en/wr_data push side; rd_en pop strobe;
//        rd_data head word (0 while empty); empty, full, count status.
module rb_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_rd, do_wr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Head is masked while empty so the output reads 0 out of reset
  // without needing to clear the storage array.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/dac_readback_rx.sv
// Purpose : captures the DAC sdo readback stream framed by sclk/latch and queues 16-bit words.
// Latency : raw edge sampled at edge k acts at k+3; word readable after edge k+4 from latch rise.
// Backpr. : none toward the DAC; a frame finishing into a full FIFO (no same-cycle pop) is dropped and sets overflow.
//
// Ports: clk, rst (sync, active high); sclk, latch (active-low SYNC), sdo_bit observed from the SPI link;
//        capture_en host enable; rd_en pop strobe; rd_data/empty/full/count FIFO status;
//        overflow, frame_err sticky error flags.
// Build option: define DAC_RB_FRAME_CHECK_EN to discard frames whose bit count differs from
//        FRAME_BITS and flag them on frame_err; otherwise frame_err is 0 and every frame pushes.
module dac_readback_rx
  import dac_rb_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sclk,
  input  logic                            latch,
  input  logic                            sdo_bit,
  input  logic                            capture_en,
  input  logic                            rd_en,
  output logic [DATA_BITS-1:0]            rd_data,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow,
  output logic                            frame_err
);

  // Input conditioning: sdo synchronizer, matching delay on sclk/latch,
  // a third flop for edge detect, then a registered edge pulse.
  logic                 sdo_s1_q, sdo_s1_d;
  logic                 sdo_s2_q, sdo_s2_d;
  logic [2:0]           sclk_dly_q, sclk_dly_d;
  logic [2:0]           latch_dly_q, latch_dly_d;
  logic                 sclk_fall_q, sclk_fall_d;
  logic                 latch_fall_q, latch_fall_d;
  logic                 latch_rise_q, latch_rise_d;

  rb_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 fifo_wr;
  logic                 fifo_can_wr;

`ifdef DAC_RB_FRAME_CHECK_EN
  logic                 frame_err_q, frame_err_d;
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign overflow = overflow_q;

  // A full FIFO still takes the word if the host pops in the same cycle.
  assign fifo_can_wr = !full || (rd_en && !empty);

  always_comb begin
    sdo_s1_d     = sdo_bit;
    sdo_s2_d     = sdo_s1_q;
    sclk_dly_d   = {sclk_dly_q[1:0], sclk};
    latch_dly_d  = {latch_dly_q[1:0], latch};
    sclk_fall_d  = !sclk_dly_q[1] &&  sclk_dly_q[2];
    latch_fall_d = !latch_dly_q[1] &&  latch_dly_q[2];
    latch_rise_d =  latch_dly_q[1] && !latch_dly_q[2];
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    overflow_d  = overflow_q;
    fifo_wr     = 1'b0;
`ifdef DAC_RB_FRAME_CHECK_EN
    frame_err_d = frame_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // capture_en only gates the start of a frame; it cannot abort one.
        if (capture_en && latch_fall_q) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // sclk edge is applied first so a coincident latch edge sees the new bit.
        if (sclk_fall_q) begin
          shift_d   = {shift_q[DATA_BITS-2:0], sdo_s2_q};
          bit_cnt_d = sat_inc(bit_cnt_q);
        end
        if (latch_fall_q) begin
          // SYNC glitch: restart the frame from scratch.
          shift_d   = '0;
          bit_cnt_d = '0;
        end else if (latch_rise_q) begin
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        state_d = ST_IDLE;
`ifdef DAC_RB_FRAME_CHECK_EN
        if (bit_cnt_q != BIT_CNT_W'(FRAME_BITS)) begin
          frame_err_d = 1'b1;
        end else if (fifo_can_wr) begin
          fifo_wr = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
`else
        if (fifo_can_wr) begin
          fifo_wr = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdo_s1_q     <= 1'b0;
      sdo_s2_q     <= 1'b0;
      sclk_dly_q   <= '0;
      latch_dly_q  <= '0;
      sclk_fall_q  <= 1'b0;
      latch_fall_q <= 1'b0;
      latch_rise_q <= 1'b0;
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      overflow_q   <= 1'b0;
`ifdef DAC_RB_FRAME_CHECK_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      sdo_s1_q     <= sdo_s1_d;
      sdo_s2_q     <= sdo_s2_d;
      sclk_dly_q   <= sclk_dly_d;
      latch_dly_q  <= latch_dly_d;
      sclk_fall_q  <= sclk_fall_d;
      latch_fall_q <= latch_fall_d;
      latch_rise_q <= latch_rise_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      overflow_q   <= overflow_d;
`ifdef DAC_RB_FRAME_CHECK_EN
      frame_err_q  <= frame_err_d;
`endif
    end
  end

  rb_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: tb/tb_dac_readback_rx.sv
// Purpose : directed self-checking bench for dac_readback_rx (frame table plus corner sequences).
// Latency : checks the k+3 / k+4 latch-rise-to-word timing explicitly.
// Backpr. : exercises FIFO full, overflow and push-with-pop on a full FIFO.
module tb_dac_readback_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        latch;
  logic        sdo_bit;
  logic        capture_en;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic        frame_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_readback_rx dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .latch      (latch),
    .sdo_bit    (sdo_bit),
    .capture_en (capture_en),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  typedef struct {
    int          nbits;
    logic [31:0] data;
    int          cap_mode;   // 0 off, 1 on, 2 on then dropped mid-frame
    bit          exp_push;
    logic [15:0] exp_word;
    logic [4:0]  exp_count;
    logic        exp_ferr;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // sclk half-period of 2 clk; sdo changes with the sclk rise, sampled on the fall.
  task automatic send_frame(input int nbits, input logic [31:0] data, input int cap_mode,
                            input int rst_after, input bit wait_end);
    capture_en = (cap_mode != 0);
    latch      = 1'b0;
    repeat (2) tick();
    if (cap_mode == 2) begin
      repeat (3) tick();
      capture_en = 1'b0;
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk    = 1'b1;
      sdo_bit = data[i];
      repeat (2) tick();
      sclk    = 1'b0;
      repeat (2) tick();
      if (rst_after > 0 && (nbits - i) == rst_after) begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end
    end
    latch = 1'b1;
    if (wait_end) repeat (8) tick();
  endtask

  task automatic drain_check(input string name);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, " head"}, {16'h0, rd_data}, {16'h0, exp_q[i]});
      pop();
    end
    chk({name, " empty"}, {31'h0, empty}, 32'h1);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; latch = 1'b1; sdo_bit = 1'b0;
    capture_en = 1'b0; rd_en = 1'b0;

    vecs[0] = '{24, 32'h0000_CAFE, 0, 1'b0, 16'h0000, 5'd0, 1'b0};
    vecs[1] = '{24, 32'h0012_3456, 1, 1'b1, 16'h3456, 5'd1, 1'b0};
    vecs[2] = '{24, 32'h00FF_0001, 1, 1'b1, 16'h0001, 5'd2, 1'b0};
    vecs[3] = '{24, 32'h0000_BEAD, 2, 1'b1, 16'hBEAD, 5'd3, 1'b0};
`ifdef DAC_RB_FRAME_CHECK_EN
    vecs[4] = '{20, 32'h000F_ABCD, 1, 1'b0, 16'h0000, 5'd3, 1'b1};
    vecs[5] = '{28, 32'h0987_6543, 1, 1'b0, 16'h0000, 5'd3, 1'b1};
`else
    vecs[4] = '{20, 32'h000F_ABCD, 1, 1'b1, 16'hABCD, 5'd4, 1'b0};
    vecs[5] = '{28, 32'h0987_6543, 1, 1'b1, 16'h6543, 5'd5, 1'b0};
`endif

    // Reset state.
    do_reset();
    chk("rst rd_data",   {16'h0, rd_data},  32'h0);
    chk("rst empty",     {31'h0, empty},    32'h1);
    chk("rst full",      {31'h0, full},     32'h0);
    chk("rst count",     {27'h0, count},    32'h0);
    chk("rst overflow",  {31'h0, overflow}, 32'h0);
    chk("rst frame_err", {31'h0, frame_err},32'h0);

    // First frame with exact latency: latch sampled at k, word visible after k+4.
    send_frame(24, 32'h00A5_1234, 1, 0, 1'b0);
    repeat (4) tick();
    chk("lat count k+3", {27'h0, count}, 32'h0);
    chk("lat empty k+3", {31'h0, empty}, 32'h1);
    tick();
    chk("lat count k+4",   {27'h0, count},   32'h1);
    chk("lat rd_data k+4", {16'h0, rd_data}, 32'h1234);
    chk("lat empty k+4",   {31'h0, empty},   32'h0);
    repeat (4) tick();
    chk("lat frame_err", {31'h0, frame_err}, 32'h0);
    pop();
    chk("lat pop count", {27'h0, count}, 32'h0);

    // Frame table.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].nbits, vecs[v].data, vecs[v].cap_mode, 0, 1'b1);
      chk($sformatf("vec%0d count", v),     {27'h0, count},     {27'h0, vecs[v].exp_count});
      chk($sformatf("vec%0d frame_err", v), {31'h0, frame_err}, {31'h0, vecs[v].exp_ferr});
      chk($sformatf("vec%0d overflow", v),  {31'h0, overflow},  32'h0);
      if (vecs[v].exp_push) exp_q.push_back(vecs[v].exp_word);
    end
    drain_check("table drain");

    // 17 frames, no reads: the 17th overflows.
    do_reset();
    for (int i = 1; i <= 17; i++) send_frame(24, i, 1, 0, 1'b1);
    chk("ovf full",     {31'h0, full},     32'h1);
    chk("ovf overflow", {31'h0, overflow}, 32'h1);
    chk("ovf count",    {27'h0, count},    32'd16);
    for (int i = 1; i <= 16; i++) exp_q.push_back(16'(i));
    drain_check("ovf drain");
    chk("ovf sticky", {31'h0, overflow}, 32'h1);

    // Full FIFO, PUSH coincides with a pop.
    do_reset();
    for (int i = 1; i <= 16; i++) send_frame(24, i, 1, 0, 1'b1);
    chk("pp full before", {31'h0, full}, 32'h1);
    send_frame(24, 32'h0000_0077, 1, 0, 1'b0);
    repeat (4) tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (4) tick();
    chk("pp count",    {27'h0, count},    32'd16);
    chk("pp overflow", {31'h0, overflow}, 32'h0);
    chk("pp full",     {31'h0, full},     32'h1);
    for (int i = 2; i <= 16; i++) exp_q.push_back(16'(i));
    exp_q.push_back(16'h0077);
    drain_check("pp drain");

    // rd_en while empty is ignored.
    pop();
    chk("rd empty count", {27'h0, count}, 32'h0);
    chk("rd empty empty", {31'h0, empty}, 32'h1);
    chk("rd empty full",  {31'h0, full},  32'h0);

    // Reset after 10 bits, released mid-frame.
    send_frame(24, 32'h0012_3456, 1, 10, 1'b1);
    chk("midrst count",    {27'h0, count},    32'h0);
    chk("midrst overflow", {31'h0, overflow}, 32'h0);
    send_frame(24, 32'h0000_BEEF, 1, 0, 1'b1);
    chk("midrst next count",   {27'h0, count},   32'h1);
    chk("midrst next rd_data", {16'h0, rd_data}, 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
